// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a request/response handshake.
// Writes are byte-lane masked and complete after a fixed busy period;
// reads return the addressed word after a programmable latency and hold
// it until the initiator accepts it.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] read_cnt,
  output logic [31:0] write_cnt
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_WBUSY,
    S_RWAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_req_ready;
  logic                  r_rd_valid;
  logic [31:0]           r_rdata;
  logic [31:0]           r_read_cnt;
  logic [31:0]           r_write_cnt;
  logic [31:0]           r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_unused_addr;

  // Byte offset and bits beyond the memory size do not select a word,
  // so addresses alias modulo the memory size.
  assign w_idx         = Address[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  // A simultaneous read and write is taken as a write only.
  assign w_wr_acc = (r_state == S_IDLE) && MemWrite;
  assign w_rd_acc = (r_state == S_IDLE) && MemRead && !MemWrite;

  assign Mem_Req_Ready   = r_req_ready;
  assign Read_data_Valid = r_rd_valid;
  assign Read_data       = r_rdata;
  assign read_cnt        = r_read_cnt;
  assign write_cnt       = r_write_cnt;

  // Storage array: byte-lane write at acceptance, untouched by reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (Write_strb[i]) begin
          r_mem[w_idx][8*i +: 8] <= Write_data[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs, read capture and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RST;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_req_ready <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rdata     <= 32'd0;
      r_read_cnt  <= 32'd0;
      r_write_cnt <= 32'd0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        S_IDLE: begin
          if (w_wr_acc) begin
            r_state     <= S_WBUSY;
            r_cnt       <= LAT_M1;
            r_write_cnt <= r_write_cnt + 32'd1;
            r_req_ready <= 1'b0;
          end else if (w_rd_acc) begin
            r_state     <= S_RWAIT;
            r_cnt       <= LAT_M1;
            r_idx       <= w_idx;
            r_req_ready <= 1'b0;
          end
        end
        S_WBUSY: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RWAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= S_RESP;
            r_rdata    <= r_mem[r_idx];
            r_rd_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (Read_data_Ready) begin
            r_state     <= S_IDLE;
            r_rd_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_read_cnt  <= r_read_cnt + 32'd1;
          end
        end
        default: begin
          r_state     <= S_RST;
          r_req_ready <= 1'b0;
          r_rd_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
